g_lane_judge: RTL and testbench

G_LANE_JUDGE -- requirements
Module: g_lane_judge

---
 rtl/g_lane_judge.sv | 177 +++++++++++++++++
 tb/tb_g_lane_judge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/g_lane_judge.sv
// g_lane_judge
// Judges key presses against falling blocks in a single rhythm-game lane.
// The lane's block generator reports the current block height every beat;
// this block watches for a new block appearing (spawn), the block reaching
// the bottom, and key presses. It decides hit / perfect / miss and keeps
// score and combo statistics.
//
// Ports
//   clk              beat-rate clock shared with the lane's block generator
//   rst              synchronous active-high reset
//   restart          synchronous active-high game restart (same effect as rst)
//   stop_or_endgame  freezes all judgement while high
//   block_h[9:0]     current block height
//   key_in           debounced key level, 1 = pressed
//   hit              one-cycle pulse on a hit
//   perfect          one-cycle pulse alongside hit when inside the perfect band
//   miss             one-cycle pulse on a miss
//   score[9:0]       accumulated score, saturates at 999
//   combo[6:0]       current run of consecutive hits, saturates at 99
//   max_combo[6:0]   best combo since the last reset or restart
//   state[1:0]       FSM state: IDLE=0, FALLING=1, JUDGED=2

module g_lane_judge #(
   parameter int H_IDLE  = 720,
   parameter int H_SPAWN = 120,
   parameter int WIN_LO  = 560,
   parameter int WIN_HI  = 660,
   parameter int PERF_LO = 600,
   parameter int PERF_HI = 620
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   input  logic       stop_or_endgame,
   input  logic [9:0] block_h,
   input  logic       key_in,
   output logic       hit,
   output logic       perfect,
   output logic       miss,
   output logic [9:0] score,
   output logic [6:0] combo,
   output logic [6:0] max_combo,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FALLING = 2'd1,
      ST_JUDGED  = 2'd2,
      ST_UNUSED  = 2'd3
   } state_t;

   localparam logic [9:0] H_IDLE_V  = 10'(H_IDLE);
   localparam logic [9:0] H_SPAWN_V = 10'(H_SPAWN);
   localparam logic [9:0] WIN_LO_V  = 10'(WIN_LO);
   localparam logic [9:0] WIN_HI_V  = 10'(WIN_HI);
   localparam logic [9:0] PERF_LO_V = 10'(PERF_LO);
   localparam logic [9:0] PERF_HI_V = 10'(PERF_HI);

   state_t     state_q, state_d;
   logic [9:0] score_q, score_d;
   logic [6:0] combo_q, combo_d;
   logic [6:0] max_combo_q, max_combo_d;
   logic       hit_q, hit_d;
   logic       perfect_q, perfect_d;
   logic       miss_q, miss_d;
   logic       key_q;
   logic [9:0] prev_h_q;

   logic       key_edge;
   logic       spawn;
   logic       bottom;
   logic       in_win;
   logic       in_perf;
   logic [10:0] score_sum;

   // Event decoding from the live inputs and the previous-cycle samples.
   // spawn needs the previous height so a block parked at H_SPAWN for several
   // beats only counts once.
   always_comb begin
      key_edge = key_in & ~key_q;
      spawn    = (block_h == H_SPAWN_V) && (prev_h_q != H_SPAWN_V);
      bottom   = (block_h == H_IDLE_V);
      in_win   = (block_h >= WIN_LO_V) && (block_h <= WIN_HI_V);
      in_perf  = (block_h >= PERF_LO_V) && (block_h <= PERF_HI_V);
   end

   // Next-state and judgement logic. Spawn beats a key press beats reaching
   // the bottom, so at most one pulse is produced per beat. While frozen
   // everything holds and no pulse is produced.
   always_comb begin
      state_d   = state_q;
      hit_d     = 1'b0;
      perfect_d = 1'b0;
      miss_d    = 1'b0;
      if (!stop_or_endgame) begin
         case (state_q)
            ST_IDLE: begin
               if (spawn) state_d = ST_FALLING;
            end
            ST_FALLING: begin
               if (spawn) begin
                  miss_d = 1'b1;
               end else if (key_edge) begin
                  state_d = ST_JUDGED;
                  if (in_win) begin
                     hit_d     = 1'b1;
                     perfect_d = in_perf;
                  end else begin
                     miss_d = 1'b1;
                  end
               end else if (bottom) begin
                  miss_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_JUDGED: begin
               if (spawn) state_d = ST_FALLING;
               else if (bottom) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Score and combo bookkeeping driven by the pulses decided above. The
   // score sum is one bit wider so the saturation test cannot wrap.
   always_comb begin
      score_sum   = {1'b0, score_q} + (perfect_d ? 11'd2 : 11'd1);
      score_d     = score_q;
      combo_d     = combo_q;
      max_combo_d = max_combo_q;
      if (hit_d) begin
         score_d = (score_sum > 11'd999) ? 10'd999 : score_sum[9:0];
         combo_d = (combo_q < 7'd99) ? combo_q + 7'd1 : 7'd99;
      end else if (miss_d) begin
         combo_d = 7'd0;
      end
      if (combo_d > max_combo_q) max_combo_d = combo_d;
   end

   // Register stage. key_q and prev_h_q keep sampling while frozen so that a
   // key pressed during a freeze is not seen as a fresh press afterwards.
   // key_q resets to 1 so a key held through reset is not a press.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         state_q     <= ST_IDLE;
         score_q     <= 10'd0;
         combo_q     <= 7'd0;
         max_combo_q <= 7'd0;
         hit_q       <= 1'b0;
         perfect_q   <= 1'b0;
         miss_q      <= 1'b0;
         key_q       <= 1'b1;
         prev_h_q    <= H_IDLE_V;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         combo_q     <= combo_d;
         max_combo_q <= max_combo_d;
         hit_q       <= hit_d;
         perfect_q   <= perfect_d;
         miss_q      <= miss_d;
         key_q       <= key_in;
         prev_h_q    <= block_h;
      end
   end

   assign hit       = hit_q;
   assign perfect   = perfect_q;
   assign miss      = miss_q;
   assign score     = score_q;
   assign combo     = combo_q;
   assign max_combo = max_combo_q;
   assign state     = state_q;

endmodule

// File: tb/tb_g_lane_judge.sv
// tb_g_lane_judge
// Scenario bench for g_lane_judge. Each scenario task builds a table of
// beats, drives them one per clock, pushes the expected pulses/state to a
// scoreboard queue and pops and compares after each edge.

module tb_g_lane_judge;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FALL = 2'd1;
   localparam logic [1:0] S_JUDG = 2'd2;

   typedef struct packed {
      logic [9:0] h;
      logic       k;
      logic       stp;
      logic       rs;
      logic       eh;
      logic       ep;
      logic       em;
      logic [1:0] st;
   } row_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       restart;
   logic       stop_or_endgame;
   logic [9:0] block_h;
   logic       key_in;
   logic       hit;
   logic       perfect;
   logic       miss;
   logic [9:0] score;
   logic [6:0] combo;
   logic [6:0] max_combo;
   logic [1:0] state;

   int   checks = 0;
   int   errors = 0;
   row_t exp_q[$];

   g_lane_judge dut (
      .clk(clk),
      .rst(rst),
      .restart(restart),
      .stop_or_endgame(stop_or_endgame),
      .block_h(block_h),
      .key_in(key_in),
      .hit(hit),
      .perfect(perfect),
      .miss(miss),
      .score(score),
      .combo(combo),
      .max_combo(max_combo),
      .state(state)
   );

   // Free-running beat clock.
   always #5 clk = ~clk;

   function automatic row_t mk(input int h, input logic k, input logic stp, input logic rs,
                               input logic eh, input logic ep, input logic em, input logic [1:0] st);
      row_t r;
      r.h = 10'(h); r.k = k; r.stp = stp; r.rs = rs;
      r.eh = eh; r.ep = ep; r.em = em; r.st = st;
      return r;
   endfunction

   // Drives one beat, records its expected outcome and waits past the edge.
   task automatic applyStimulus(input row_t r);
      block_h         = r.h;
      key_in          = r.k;
      stop_or_endgame = r.stp;
      restart         = r.rs;
      exp_q.push_back(r);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; restart = 1'b0; stop_or_endgame = 1'b1;
      block_h = 10'd720; key_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; stop_or_endgame = 1'b0;
      checks++;
      if ({hit, perfect, miss, state, score, combo, max_combo} !== 26'd0) begin
         errors++;
         $display("[TB] FAIL reset: hit/perf/miss=%b%b%b state=%0d score=%0d combo=%0d max=%0d, required all 0",
                  hit, perfect, miss, state, score, combo, max_combo);
      end
   endtask

   task automatic test_perfect_hit();
      row_t rows[7];
      row_t e;
      rows[0] = mk(720, 0, 0, 0, 0, 0, 0, S_IDLE);
      rows[1] = mk(120, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[2] = mk(300, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[3] = mk(560, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[4] = mk(610, 1, 0, 0, 1, 1, 0, S_JUDG);
      rows[5] = mk(640, 1, 0, 0, 0, 0, 0, S_JUDG);
      rows[6] = mk(720, 0, 0, 0, 0, 0, 0, S_IDLE);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(rows[i]);
         e = exp_q.pop_front();
         checks++;
         if ({hit, perfect, miss, state} !== {e.eh, e.ep, e.em, e.st}) begin
            errors++;
            $display("[TB] FAIL perfect_hit beat %0d: hit/perf/miss/state=%b%b%b/%0d, required %b%b%b/%0d",
                     i, hit, perfect, miss, state, e.eh, e.ep, e.em, e.st);
         end
      end
      checks++;
      if (score !== 10'd2 || combo !== 7'd1 || max_combo !== 7'd1) begin
         errors++;
         $display("[TB] FAIL perfect_hit counters: score/combo/max=%0d/%0d/%0d, required 2/1/1", score, combo, max_combo);
      end
   endtask

   task automatic test_early_key_miss();
      row_t rows[4];
      row_t e;
      rows[0] = mk(120, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[1] = mk(300, 1, 0, 0, 0, 0, 1, S_JUDG);
      rows[2] = mk(500, 1, 0, 0, 0, 0, 0, S_JUDG);
      rows[3] = mk(720, 0, 0, 0, 0, 0, 0, S_IDLE);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(rows[i]);
         e = exp_q.pop_front();
         checks++;
         if ({hit, perfect, miss, state} !== {e.eh, e.ep, e.em, e.st}) begin
            errors++;
            $display("[TB] FAIL early_key beat %0d: hit/perf/miss/state=%b%b%b/%0d, required %b%b%b/%0d",
                     i, hit, perfect, miss, state, e.eh, e.ep, e.em, e.st);
         end
      end
      checks++;
      if (score !== 10'd2 || combo !== 7'd0 || max_combo !== 7'd1) begin
         errors++;
         $display("[TB] FAIL early_key counters: score/combo/max=%0d/%0d/%0d, required 2/0/1", score, combo, max_combo);
      end
   endtask

   task automatic test_bottom_miss();
      row_t rows[7];
      row_t e;
      rows[0] = mk(120, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[1] = mk(400, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[2] = mk(650, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[3] = mk(720, 0, 0, 0, 0, 0, 1, S_IDLE);
      rows[4] = mk(720, 0, 0, 0, 0, 0, 0, S_IDLE);
      rows[5] = mk(720, 1, 0, 0, 0, 0, 0, S_IDLE);
      rows[6] = mk(720, 0, 0, 0, 0, 0, 0, S_IDLE);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(rows[i]);
         e = exp_q.pop_front();
         checks++;
         if ({hit, perfect, miss, state} !== {e.eh, e.ep, e.em, e.st}) begin
            errors++;
            $display("[TB] FAIL bottom_miss beat %0d: hit/perf/miss/state=%b%b%b/%0d, required %b%b%b/%0d",
                     i, hit, perfect, miss, state, e.eh, e.ep, e.em, e.st);
         end
      end
   endtask

   task automatic test_stop_freeze();
      row_t rows[24];
      row_t e;
      rows[0] = mk(120, 0, 0, 0, 0, 0, 0, S_FALL);
      for (int i = 0; i < 20; i++) begin
         if (i < 10) rows[1 + i] = mk(300 + 25 * i, 0, 1, 0, 0, 0, 0, S_FALL);
         else        rows[1 + i] = mk(610, 1, 1, 0, 0, 0, 0, S_FALL);
      end
      rows[21] = mk(620, 1, 0, 0, 0, 0, 0, S_FALL);
      rows[22] = mk(630, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[23] = mk(640, 1, 0, 0, 1, 0, 0, S_JUDG);
      for (int i = 0; i < 24; i++) begin
         applyStimulus(rows[i]);
         e = exp_q.pop_front();
         checks++;
         if ({hit, perfect, miss, state} !== {e.eh, e.ep, e.em, e.st}) begin
            errors++;
            $display("[TB] FAIL stop_freeze beat %0d: hit/perf/miss/state=%b%b%b/%0d, required %b%b%b/%0d",
                     i, hit, perfect, miss, state, e.eh, e.ep, e.em, e.st);
         end
         if (i == 20) begin
            checks++;
            if (score !== 10'd2 || combo !== 7'd0 || max_combo !== 7'd1) begin
               errors++;
               $display("[TB] FAIL stop_hold counters: score/combo/max=%0d/%0d/%0d, required 2/0/1", score, combo, max_combo);
            end
         end
      end
      checks++;
      if (score !== 10'd3 || combo !== 7'd1 || max_combo !== 7'd1) begin
         errors++;
         $display("[TB] FAIL stop_resume counters: score/combo/max=%0d/%0d/%0d, required 3/1/1", score, combo, max_combo);
      end
   endtask

   task automatic test_respawn();
      row_t rows[5];
      row_t e;
      rows[0] = mk(120, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[1] = mk(400, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[2] = mk(120, 1, 0, 0, 0, 0, 1, S_FALL);
      rows[3] = mk(200, 1, 0, 0, 0, 0, 0, S_FALL);
      rows[4] = mk(720, 0, 0, 0, 0, 0, 1, S_IDLE);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(rows[i]);
         e = exp_q.pop_front();
         checks++;
         if ({hit, perfect, miss, state} !== {e.eh, e.ep, e.em, e.st}) begin
            errors++;
            $display("[TB] FAIL respawn beat %0d: hit/perf/miss/state=%b%b%b/%0d, required %b%b%b/%0d",
                     i, hit, perfect, miss, state, e.eh, e.ep, e.em, e.st);
         end
         if (i == 2) begin
            checks++;
            if (combo !== 7'd0 || score !== 10'd3) begin
               errors++;
               $display("[TB] FAIL respawn counters: score/combo=%0d/%0d, required 3/0", score, combo);
            end
         end
      end
   endtask

   task automatic test_restart();
      row_t rows[7];
      row_t e;
      rows[0] = mk(120, 0, 0, 0, 0, 0, 0, S_FALL);
      rows[1] = mk(610, 1, 0, 1, 0, 0, 0, S_IDLE);
      rows[2] = mk(120, 0, 1, 1, 0, 0, 0, S_IDLE);
      rows[3] = mk(720, 1, 0, 1, 0, 0, 0, S_IDLE);
      rows[4] = mk(120, 1, 0, 0, 0, 0, 0, S_FALL);
      rows[5] = mk(610, 1, 0, 0, 0, 0, 0, S_FALL);
      rows[6] = mk(720, 1, 0, 0, 0, 0, 1, S_IDLE);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(rows[i]);
         e = exp_q.pop_front();
         checks++;
         if ({hit, perfect, miss, state} !== {e.eh, e.ep, e.em, e.st}) begin
            errors++;
            $display("[TB] FAIL restart beat %0d: hit/perf/miss/state=%b%b%b/%0d, required %b%b%b/%0d",
                     i, hit, perfect, miss, state, e.eh, e.ep, e.em, e.st);
         end
         if (i == 1) begin
            checks++;
            if (score !== 10'd0 || combo !== 7'd0 || max_combo !== 7'd0) begin
               errors++;
               $display("[TB] FAIL restart counters: score/combo/max=%0d/%0d/%0d, required 0/0/0", score, combo, max_combo);
            end
         end
      end
   endtask

   task automatic test_saturation();
      row_t e;
      for (int i = 0; i < 502; i++) begin
         applyStimulus(mk(120, 0, 0, 0, 0, 0, 0, S_FALL));
         if (i < 501) applyStimulus(mk(610, 1, 0, 0, 1, 1, 0, S_JUDG));
         else         applyStimulus(mk(650, 1, 0, 0, 1, 0, 0, S_JUDG));
         for (int j = 0; j < 2; j++) begin
            e = exp_q.pop_front();
            if (j == 1) begin
               checks++;
               if ({hit, perfect, miss, state} !== {e.eh, e.ep, e.em, e.st}) begin
                  errors++;
                  $display("[TB] FAIL saturation hit %0d: hit/perf/miss/state=%b%b%b/%0d, required %b%b%b/%0d",
                           i, hit, perfect, miss, state, e.eh, e.ep, e.em, e.st);
               end
            end
         end
         if (i == 498 || i == 499 || i == 501) begin
            checks++;
            if (score !== ((i == 498) ? 10'd998 : 10'd999) || combo !== 7'd99 || max_combo !== 7'd99) begin
               errors++;
               $display("[TB] FAIL saturation counters after hit %0d: score/combo/max=%0d/%0d/%0d, required %0d/99/99",
                        i, score, combo, max_combo, (i == 498) ? 998 : 999);
            end
         end
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_perfect_hit();
      test_early_key_miss();
      test_bottom_miss();
      test_stop_freeze();
      test_respawn();
      test_restart();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
